fir_tap_seq: RTL and testbench

- Time-multiplexed FIR tap sequencer for the log-domain adaptive filter.
- Computes all ORD tap products through one shared log-multiplier lane instead of ORD parallel lanes, and accumulates them into one filter output sample.
- Sits between the tap-delay/weight registers, which supply the packed operands, and a single shared log multiplier (sign/abs, log conversion, log multiply) outside this block.
- Sequences operand issue, tracks pipelined returns and reports the result with a start/done handshake.

---
 rtl/fir_tap_seq.sv | 141 ++++++++++++++
 tb/tb_fir_tap_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_seq.sv
// fir_tap_seq: time-multiplexed FIR tap sequencer feeding one shared log-multiplier lane.
// Latency: start at edge t -> mul_req on cycles t+1..t+ORD, done on cycle t+ORD+MUL_LAT+1.
// Backpressure: none; start is accepted only in IDLE or DONE, otherwise dropped (no queuing).
// Optional build macro FIR_SEQ_SAT_EN: saturate y_out to the signed WIDTH range instead of wrapping.
module fir_tap_seq #(
  parameter int WIDTH   = 16,
  parameter int QP      = 12,
  parameter int ORD     = 64,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ORD*WIDTH-1:0]   filter_in_packed,
  input  logic [ORD*WIDTH-1:0]   weight_in_packed,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_req,
  input  logic [WIDTH-1:0]       mul_prod,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       y_out
);

  // Products arrive already scaled by the multiplier, so QP only constrains legal configs.
  if (MUL_LAT < 1 || QP >= WIDTH) begin : g_bad_param
    $error("fir_tap_seq: MUL_LAT must be >= 1 and QP < WIDTH");
  end

  localparam int IW = (ORD > 1) ? $clog2(ORD) : 1;
  localparam int AW = WIDTH + $clog2(ORD);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(ORD - 1);
  // Pipe pattern meaning "only the final return is still outstanding".
  localparam logic [MUL_LAT-1:0] PIPE_LAST = MUL_LAT'(1) << (MUL_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [ORD*WIDTH-1:0]   tap_q;
  logic [ORD*WIDTH-1:0]   wgt_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   prod_ext;
  logic [MUL_LAT-1:0]     pipe_q;
  logic [MUL_LAT-1:0]     pipe_d;
  logic [WIDTH-1:0]       mul_a_q;
  logic [WIDTH-1:0]       mul_b_q;
  logic                   mul_req_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH-1:0]       y_q;
  logic [WIDTH-1:0]       y_red;
  logic                   last_ret;

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign mul_req = mul_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_out   = y_q;

  // Return tracking and accumulation of sign-extended products on marked cycles.
  always_comb begin
    prod_ext = AW'($signed(mul_prod));
    pipe_d   = (pipe_q << 1) | MUL_LAT'(mul_req_q);
    acc_d    = pipe_q[MUL_LAT-1] ? (acc_q + prod_ext) : acc_q;
    // Final return is in its landing cycle and nothing else is in flight.
    last_ret = (state_q == S_DRAIN) && !mul_req_q && (pipe_q == PIPE_LAST);
  end

  // Reduce the wide accumulator (including the return landing now) to the output width.
  always_comb begin
`ifdef FIR_SEQ_SAT_EN
    if (acc_d > AW'((1 << (WIDTH - 1)) - 1)) begin
      y_red = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (acc_d < AW'(-(1 << (WIDTH - 1)))) begin
      y_red = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      y_red = acc_d[WIDTH-1:0];
    end
`else
    y_red = acc_d[WIDTH-1:0];
`endif
  end

  // Sequencer FSM with registered multiplier operands and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      pipe_q    <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_q       <= '0;
    end else begin
      pipe_q    <= pipe_d;
      acc_q     <= acc_d;
      mul_req_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        // The done cycle also accepts a new start to reach ORD+MUL_LAT+2 throughput.
        S_IDLE, S_DONE: begin
          if (start) begin
            tap_q   <= filter_in_packed;
            wgt_q   <= weight_in_packed;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          mul_req_q <= 1'b1;
          mul_a_q   <= tap_q[WIDTH*idx_q +: WIDTH];
          mul_b_q   <= wgt_q[WIDTH*idx_q +: WIDTH];
          idx_q     <= idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_ret) begin
            y_q     <= y_red;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_seq.sv
// Directed bench for fir_tap_seq (ORD=4, MUL_LAT=2) with a delayed-product multiplier model.
// Expected outputs are queued at start and popped when done pulses.
module tb_fir_tap_seq;
  localparam int W   = 16;
  localparam int QP  = 12;
  localparam int ORD = 4;
  localparam int ML  = 2;

  typedef logic [W-1:0] vec_t [ORD];

  logic             clk;
  logic             reset;
  logic             start;
  logic [ORD*W-1:0] filter_in_packed;
  logic [ORD*W-1:0] weight_in_packed;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_req;
  logic [W-1:0]     mul_prod;
  logic             busy;
  logic             done;
  logic [W-1:0]     y_out;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q [$];

  fir_tap_seq #(.WIDTH(W), .QP(QP), .ORD(ORD), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start),
    .filter_in_packed(filter_in_packed), .weight_in_packed(weight_in_packed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_req(mul_req), .mul_prod(mul_prod),
    .busy(busy), .done(done), .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mdl_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    p = p >>> QP;
    return p[W-1:0];
  endfunction

  // Shared multiplier model: product appears ML cycles after its operands.
  logic [W-1:0] mp0, mp1;
  always @(posedge clk) begin
    mp0 <= mdl_mul(mul_a, mul_b);
    mp1 <= mp0;
  end
  assign mul_prod = mp1;

  function automatic logic [W-1:0] mdl_sum(input vec_t t, input vec_t w);
    int s;
    logic [W-1:0] p;
    s = 0;
    for (int k = 0; k < ORD; k++) begin
      p = mdl_mul(t[k], w[k]);
      s += int'($signed(p));
    end
`ifdef FIR_SEQ_SAT_EN
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[W-1:0];
  endfunction

  function automatic logic [ORD*W-1:0] pack(input vec_t v);
    logic [ORD*W-1:0] r;
    for (int k = 0; k < ORD; k++) r[W*k +: W] = v[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One evaluation; optionally hammers start and scrambles the buses mid-run.
  task automatic run(input string tag, input vec_t t, input vec_t w, input bit disturb);
    int first, last, nreq, ndone, dn;
    logic [W-1:0] y_exp;
    first = -1; last = -1; nreq = 0; ndone = 0; dn = -1;
    y_exp = mdl_sum(t, w);
    exp_q.push_back(y_exp);
    filter_in_packed = pack(t);
    weight_in_packed = pack(w);
    start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (disturb && n < 5) begin
        start = 1'b1;
        filter_in_packed = ~filter_in_packed;
        weight_in_packed = {weight_in_packed[W-1:0], weight_in_packed[ORD*W-1:W]};
      end else begin
        start = 1'b0;
      end
      if (n == 3) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (mul_req) begin
        if (first < 0) first = n;
        last = n;
        nreq++;
      end
      if (done) begin
        ndone++;
        if (dn < 0) dn = n;
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk({tag, "_y"}, 32'(y_out), 32'(exp_q.pop_front()));
      end
    end
    chk({tag, "_req_first"}, 32'(first), 32'd1);
    chk({tag, "_req_last"}, 32'(last), 32'(ORD));
    chk({tag, "_req_cnt"}, 32'(nreq), 32'(ORD));
    chk({tag, "_done_cyc"}, 32'(dn), 32'(ORD + ML + 1));
    chk({tag, "_done_cnt"}, 32'(ndone), 32'd1);
    chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_y_hold"}, 32'(y_out), 32'(y_exp));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Watches a quiet window and checks that nothing is issued or completed.
  task automatic quiet(input string tag, input int cycles);
    int nreq, ndone;
    nreq = 0; ndone = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (mul_req) nreq++;
      if (done) ndone++;
    end
    chk({tag, "_no_req"}, 32'(nreq), 32'd0);
    chk({tag, "_no_done"}, 32'(ndone), 32'd0);
  endtask

  vec_t ta, wa;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    filter_in_packed = '0;
    weight_in_packed = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_req", 32'(mul_req), 32'd0);
    quiet("rst", 10);

    ta = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    wa = '{16'h0800, 16'h0400, 16'h0200, 16'h0200};
    chk("basic_model", 32'(mdl_sum(ta, wa)), 32'h1000);
    run("basic", ta, wa, 1'b0);

    ta = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
    wa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    run("signed", ta, wa, 1'b0);

    ta = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    wa = '{16'h0700, 16'h0700, 16'h0700, 16'h0700};
    run("ovf", ta, wa, 1'b0);
`ifdef FIR_SEQ_SAT_EN
    chk("ovf_const", 32'(y_out), 32'h7FFF);
`else
    chk("ovf_const", 32'(y_out), 32'hC400);
`endif

    ta = '{16'h0800, 16'h0800, 16'h0800, 16'h0800};
    wa = '{16'h1000, 16'h2000, 16'hE000, 16'h0400};
    run("disturb", ta, wa, 1'b1);
    chk("disturb_const", 32'(y_out), 32'h0A00);

    // Reset during the second ISSUE cycle aborts the run and clears y_out.
    filter_in_packed = pack(ta);
    weight_in_packed = pack(wa);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req", 32'(mul_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_y", 32'(y_out), 32'd0);
    quiet("midrst", 12);

    ta = '{16'h2000, 16'hE000, 16'h1800, 16'h0400};
    wa = '{16'h1000, 16'h0800, 16'hF800, 16'h4000};
    run("fresh", ta, wa, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
